// File: rtl/pulse_bram_reader_if.sv
// BRAM port and sample stream bundle for pulse_bram_reader.
// master = reader side; slave = BRAM plus the sample consumer.
interface pulse_bram_reader_if;
  logic [31:0] bram_addr;
  logic [31:0] bram_data_in;
  logic        bram_we;
  logic        bram_ena;
  logic [31:0] bram_data_out;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;

  modport master (
    output bram_addr,
    output bram_data_in,
    output bram_we,
    output bram_ena,
    input  bram_data_out,
    output sample_data,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  bram_addr,
    input  bram_data_in,
    input  bram_we,
    input  bram_ena,
    output bram_data_out,
    input  sample_data,
    output sample_ready,
    input  sample_valid
  );
endinterface

// File: rtl/pulse_bram_reader.sv
// Walks the pulse BRAM at a fixed tick rate and streams each word as a sample.
// Optional clear-on-read: define PULSE_READER_CLEAR_ON_READ_EN.
module pulse_bram_reader #(
  parameter int unsigned Depth   = 1024,
  parameter int unsigned RateDiv = 100
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  pulse_bram_reader_if.master        bus_io,
  output logic                       wrap_pulse_o,
  output logic [15:0]                overrun_count_o
);

`ifdef PULSE_READER_CLEAR_ON_READ_EN
  localparam bit ClearOnRead = 1'b1;
`else
  localparam bit ClearOnRead = 1'b0;
`endif

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned DivW = $clog2(RateDiv);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StRead,
    StCapture,
    StHandshake
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              ena_q, ena_d;
  logic              we_q, we_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [15:0]       ovr_q, ovr_d;
  logic              tick;

  assign tick = (state_q != StIdle) && (div_q == DivW'(RateDiv - 1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ena_d   = ena_q;
    we_d    = 1'b0;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    ovr_d   = ovr_q;

    // Divider free-runs outside idle so the sample grid never slips on stalls.
    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        ena_d = 1'b0;
        if (enable_i) begin
          idx_d   = '0;
          div_d   = '0;
          state_d = StWaitTick;
        end
      end
      StWaitTick: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (tick) begin
          addr_d  = 32'(idx_q) << 2;
          ena_d   = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        state_d = StCapture;
      end
      StCapture: begin
        data_d  = bus_io.bram_data_out;
        valid_d = 1'b1;
        we_d    = ClearOnRead;
        state_d = StHandshake;
      end
      StHandshake: begin
        ena_d = 1'b0;
        if (valid_q && bus_io.sample_ready) begin
          valid_d = 1'b0;
          wrap_d  = (idx_q == IdxW'(Depth - 1));
          idx_d   = (idx_q == IdxW'(Depth - 1)) ? '0 : idx_q + 1'b1;
          state_d = enable_i ? StWaitTick : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick that lands while a sample is in flight is dropped, not queued.
    if (tick && (state_q inside {StRead, StCapture, StHandshake}) && (ovr_q != 16'hFFFF)) begin
      ovr_d = ovr_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      div_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ena_q   <= 1'b0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus_io.bram_addr    = addr_q;
  assign bus_io.bram_data_in = '0;
  assign bus_io.bram_we      = we_q;
  assign bus_io.bram_ena     = ena_q;
  assign bus_io.sample_data  = data_q;
  assign bus_io.sample_valid = valid_q;
  assign wrap_pulse_o        = wrap_q;
  assign overrun_count_o     = ovr_q;

endmodule

// File: doc/pulse_bram_reader.md
# pulse_bram_reader

Drains the pulse-accumulation BRAM that the pulse generator fills. It walks the buffer at a fixed sample rate and presents each fp32 word as a sample on a valid/ready stream. With the optional clear-on-read, it zeroes each word after reading it so the generator accumulates into a fresh slot. It sits on the second port of the true dual-port pulse BRAM, downstream of the generator and upstream of the DAC/output formatter.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the circular buffer (power of two, ≥2).
- `RATE_DIV`, 100: clock cycles per sample tick (≥4).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request; rising edge restarts at word 0.
- `bram_addr`  out  32  byte address = index*4.
- `bram_data_in`  out  32  write data (always 32'h0).
- `bram_we`  out  1  BRAM write enable.
- `bram_ena`  out  1  BRAM port enable.
- `bram_data_out`  in  32  BRAM read data, valid one edge after address/ena.
- `sample_data`  out  32  fp32 sample.
- `sample_valid`  out  1  sample available.
- `sample_ready`  in  1  consumer accepts; transfer when valid&&ready at an edge.
- `wrap_pulse`  out  1  one-cycle strobe when index wraps DEPTH-1→0.
- `overrun_count`  out  16  saturating count of dropped ticks.

## Operation
- All outputs are registered. Reset values: `bram_addr`=0, `bram_data_in`=0, `bram_we`=0, `bram_ena`=0, `sample_data`=0, `sample_valid`=0, `wrap_pulse`=0, `overrun_count`=0. Reset also clears the index, the divider and the state (IDLE).
- Divider: a counter runs 0..RATE_DIV-1 while not in IDLE. `tick` is asserted when the counter equals RATE_DIV-1.
- States:
  - IDLE: `bram_ena`=0. When `enable`=1, clear the index and divider, then go to WAIT_TICK.
  - WAIT_TICK: on `tick`, drive `bram_addr`=index*4, `bram_ena`=1, `bram_we`=0, then go to READ. If `enable`=0, go to IDLE.
  - READ: a single cycle that waits for the BRAM read latency. `bram_ena` stays 1.
  - CAPTURE: `sample_data`<=`bram_data_out`, `sample_valid`<=1. With clear enabled, also drive `bram_we`=1 and `bram_data_in`=0 at the same address. Go to HANDSHAKE.
  - HANDSHAKE: `bram_we`=0, `bram_ena`=0. Hold `sample_valid` and `sample_data` stable until valid&&ready. On transfer: clear `sample_valid`, advance the index with wrap (DEPTH-1→0, pulse `wrap_pulse`), and return to WAIT_TICK, or to IDLE if `enable`=0.
- A `tick` arriving in READ, CAPTURE or HANDSHAKE is dropped. `overrun_count` increments and saturates at 16'hFFFF. The index does not skip.
- Deasserting `enable` mid-transaction does not abort it: the read, the clear and the handshake all complete first.
- `rst` mid-transaction aborts immediately. Any pending sample is discarded, and no write occurs on the following edge.
- Port-collision avoidance with the generator is a system-level requirement and is not arbitrated here.

## Timing
- If `tick` is high at edge E0 in WAIT_TICK:
  - `bram_addr` and `bram_ena` are valid after E0.
  - `bram_data_out` is valid after E1.
  - `sample_valid`=1 and the clear write (`bram_we`=1) occur after E2.
  - `bram_we` returns to 0 after E3.
- Tick-to-valid latency is 3 edges.
- The minimum tick-to-next-tick service time, with ready held high, is 4 edges. This is why RATE_DIV≥4.
- The divider never pauses, so the sample rate is exact regardless of consumer stalls. Stalls only cause dropped ticks.
- `wrap_pulse` is asserted for exactly 1 cycle, on the edge that accepts the DEPTH-1 sample.

## Configuration
- `PULSE_READER_CLEAR_ON_READ_EN`:
  - Defined: each captured word is overwritten with 32'h0 in the CAPTURE cycle (one-cycle `bram_we` pulse).
  - Undefined: the block is read-only. `bram_we` is constant 0, `bram_data_in` is constant 0, and timing is otherwise identical.

## Test plan
- Reset/idle: `rst`=1 for 3 cycles, `enable`=0 → all outputs 0, `bram_ena` never 1.
- Streaming: DEPTH=16, RATE_DIV=8, BRAM preloaded word k=k+1, ready tied 1, `enable`=1 → samples 1,2,…,16,1 at 8-cycle spacing. Each `sample_valid` rises 3 edges after its tick. `wrap_pulse` fires once after sample 16.
- Clear-on-read (macro defined): after one full pass, all 16 words read back 0; the second pass emits 16 zeros. With the macro undefined, the second pass repeats 1..16 and `bram_we` is never 1.
- Backpressure: ready held 0 for 20 cycles on sample 3 → `sample_data` stays 3, `overrun_count`=2 (ticks at +8 and +16 are dropped). After ready rises, the next sample is 4, not 6.
- Enable drop mid-transaction: `enable`→0 in the READ cycle → the sample still appears and clears. After the handshake the block goes IDLE with no further `bram_ena`. Re-enabling restarts at word 0.
- Reset mid-transaction: `rst` asserted in the CAPTURE cycle → `sample_valid`=0 and `bram_we`=0 on the next edge, and index=0.
